// File: rtl/ctdown_timer.sv
// Loadable down-counting timer: load a start value, decrement once per clock
// to zero, then emit a one-cycle done pulse.
module ctdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start acts as "valid" and ~busy as "ready"; a load happens
    // only on an edge where start=1 and the timer is IDLE, otherwise start is
    // dropped (not queued). done pulses for one cycle when a run completes.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             last_tick;

    assign last_tick = (cnt == WIDTH'(1));

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Priority while active: abort, then pause, then decrement.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && (load_val != '0)) state_nxt = RUN;
            end
            RUN, HOLD: begin
                if (abort)          state_nxt = IDLE;
                else if (pause)     state_nxt = HOLD;
                else if (last_tick) state_nxt = IDLE;
                else                state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cnt is always 0 in IDLE, so a zero load simply reports done.
    always_comb begin
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt  = load_val;
                    done_nxt = (load_val == '0);
                end
            end
            RUN, HOLD: begin
                if (abort) begin
                    cnt_nxt = '0;
                end else if (!pause) begin
                    cnt_nxt  = cnt - WIDTH'(1);
                    done_nxt = last_tick;
                end
            end
            default: cnt_nxt = '0;
        endcase
        busy_nxt  = (state_nxt != IDLE);
        zero      = (cnt == '0);
        dbg_state = state;
    end

endmodule

// File: tb/tb_ctdown_timer.sv
// Bench for ctdown_timer: directed scenarios plus random traffic, each edge
// compared against a cycle-level reference model of the timer's rules.
module tb_ctdown_timer;

    localparam int WIDTH = 8;
    localparam int LIMIT = 400;

    logic             ck;
    logic             res;
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic             zero;
    logic [1:0]       dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: remaining count, whether a run is active, done pulse
    int m_remain;
    bit m_active;
    bit m_done;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t exp_q[$];

    ctdown_timer #(.WIDTH(WIDTH)) dut (
        .ck        (ck),
        .res       (res),
        .start     (start),
        .load_val  (load_val),
        .pause     (pause),
        .abort     (abort),
        .cnt       (cnt),
        .busy      (busy),
        .done      (done),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_remain = 0;
        m_active = 0;
        m_done   = 0;
    endtask

    // One clock edge of the timer's rules, stated in terms of remaining work.
    task automatic model_edge(input bit s, input int lv, input bit p, input bit a);
        m_done = 0;
        if (!m_active) begin
            if (s) begin
                m_remain = lv;
                m_active = (lv != 0);
                m_done   = (lv == 0);
            end
        end else if (a) begin
            m_remain = 0;
            m_active = 0;
        end else if (!p) begin
            m_remain = m_remain - 1;
            if (m_remain == 0) begin
                m_active = 0;
                m_done   = 1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cnt"},  32'(cnt),  32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd1);
    endtask

    // driver: apply inputs at negedge, predict, compare #1 after posedge
    task automatic step(input bit s, input int lv, input bit p, input bit a);
        exp_t e;
        @(negedge ck);
        start    = s;
        load_val = WIDTH'(lv);
        pause    = p;
        abort    = a;
        model_edge(s, lv, p, a);
        exp_q.push_back('{cnt: WIDTH'(m_remain), busy: m_active, done: m_done});
        @(posedge ck);
        #1;
        e = exp_q.pop_front();
        check("cnt",  32'(cnt),  32'(e.cnt));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
        check("zero", 32'(zero), 32'(e.cnt == '0));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // steps with idle inputs until done is seen; returns edges taken
    task automatic run_until_done(output int n);
        n = 0;
        while (n < LIMIT) begin
            step(0, 0, 0, 0);
            n++;
            if (done) break;
        end
        if (n >= LIMIT) check("done_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        res      = 1'b0;
        start    = 1'b0;
        load_val = '0;
        pause    = 1'b0;
        abort    = 1'b0;
        model_reset();

        // reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            @(posedge ck);
            #1;
            check_reset_outputs("reset");
        end
        @(negedge ck);
        res = 1'b1;
        idle_steps(2);

        // basic run of 3
        step(1, 3, 0, 0);
        check("basic_start_cnt", 32'(cnt), 32'd3);
        run_until_done(n);
        check("basic_len", 32'(n), 32'd3);
        idle_steps(1);

        // pause for two cycles at cnt=3
        step(1, 5, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("pause_hold_cnt", 32'(cnt), 32'd3);
        run_until_done(n);
        check("pause_len", 32'(n + 4), 32'd7);
        idle_steps(1);

        // abort at cnt=6, then abort with pause
        step(1, 10, 0, 0);
        idle_steps(4);
        step(0, 0, 0, 1);
        idle_steps(2);
        step(1, 10, 0, 0);
        idle_steps(4);
        step(0, 0, 1, 1);
        idle_steps(2);

        // abort while in HOLD, pause/abort ignored in IDLE
        step(1, 4, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);

        // zero load
        step(1, 0, 0, 0);
        check("zero_load_done", 32'(done), 32'd1);
        idle_steps(2);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle_steps(1);

        // maximum load, no wrap
        step(1, 255, 0, 0);
        run_until_done(n);
        check("max_len", 32'(n), 32'd255);
        idle_steps(1);

        // start mid-run ignored
        step(1, 6, 0, 0);
        idle_steps(2);
        step(1, 7, 0, 0);
        check("ignored_start_cnt", 32'(cnt), 32'd3);
        idle_steps(4);

        // start on the completion edge ignored, next edge accepted
        step(1, 2, 0, 0);
        step(0, 0, 0, 0);
        step(1, 5, 0, 0);
        step(1, 5, 0, 0);
        check("restart_cnt", 32'(cnt), 32'd5);
        idle_steps(6);

        // async reset mid-run at cnt=4
        step(1, 6, 0, 0);
        idle_steps(2);
        #2;
        res = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge ck);
        #1;
        check_reset_outputs("async_rst_hold");
        @(negedge ck);
        res = 1'b1;
        step(1, 2, 0, 0);
        run_until_done(n);
        check("post_rst_len", 32'(n), 32'd2);
        idle_steps(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit s, p, a;
            int lv;
            s  = ($urandom_range(0, 3) == 0);
            lv = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
            p  = ($urandom_range(0, 4) == 0);
            a  = ($urandom_range(0, 29) == 0);
            step(s, lv, p, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ctdown_timer.md
# ctdown_timer

Loadable down-counting timer with a start/busy/done handshake: the count-down counterpart to the team's up-counters. A controller writes a start value, the block decrements once per clock to zero, then pulses `done`. It sits beside the up-counters in the counter library and is used wherever a block must wait a programmable number of cycles.

## Interface

Parameters:
- `WIDTH`, default 8: counter width in bits. Legal range is 2 to 32.

Ports:
- `ck`  in  1: clock. All state changes on the rising edge.
- `res`  in  1: reset, asynchronous, active-low. `res`=0 forces reset immediately, independent of `ck`.
- `start`  in  1: load request, sampled on rising `ck`.
- `load_val`  in  WIDTH: start value, sampled only when `start` is accepted.
- `pause`  in  1: level-sensitive hold request.
- `abort`  in  1: cancels the current run, sampled on rising `ck`.
- `cnt`  out  WIDTH: current count, registered.
- `busy`  out  1: high while in RUN or HOLD, registered.
- `done`  out  1: one-cycle completion pulse, registered.
- `zero`  out  1: combinational, equals (`cnt` == 0).

## Operation

- Reset values (`res`=0): state IDLE, `cnt`=0, `busy`=0, `done`=0, `zero`=1.
- States:
  - IDLE: not counting.
  - RUN: decrementing.
  - HOLD: paused with `cnt` frozen.
- IDLE:
  - `start`=1 with `load_val`≠0: `cnt`←`load_val`, go to RUN, `busy`←1.
  - `start`=1 with `load_val`=0: stay IDLE, `cnt`←0, `done`←1 for one cycle.
  - `pause` and `abort` have no effect in IDLE.
- Per-edge priority in RUN/HOLD: `abort`, then `pause`, then decrement.
  - `abort`=1: go to IDLE, `cnt`←0, `busy`←0, no `done` pulse.
  - Otherwise `pause`=1: go to or stay in HOLD, `cnt` unchanged.
  - Otherwise: `cnt`←`cnt`−1 and state becomes RUN. Leaving HOLD therefore decrements on the same edge.
- Completion: a decrement edge with `cnt`=1 sets `cnt`←0, state IDLE, `busy`←0 and `done`←1, all on the same edge.
- `done` is high for exactly one cycle and clears on the next edge unless a zero-load start re-asserts it.
- `start` is ignored while `busy`=1. There is no restart and no reload.
- A `start` on the edge where `done` is being asserted is ignored, because state is still RUN at that edge. A new `start` is accepted on the following edge.
- `cnt` never wraps below 0. Decrement happens only in RUN or HOLD, where `cnt`≥1.
- Arithmetic is unsigned, modulo 2^WIDTH. The maximum load is 2^WIDTH−1.

## Timing

- Latency: `start` accepted at edge k with `load_val`=N≥1.
  - After edge k: `cnt`=N, `busy`=1.
  - Without pause, after edge k+N: `cnt`=0, `busy`=0, `done`=1.
  - After edge k+N+1: `done`=0.
- Each paused cycle extends completion by exactly one cycle.
- Zero load: `start` at edge k gives `done`=1 after edge k, with `busy` never asserted.
- An abort at edge j gives `cnt`=0 and `busy`=0 after edge j, with no `done`.
- Async reset mid-run: outputs take reset values immediately. No `done` is produced. After `res` rises, the next accepted `start` begins a fresh run.
- `res` deassertion is asynchronous. The first edge after release is a normal functional edge.

## Test plan

- Reset: hold `res`=0 for 2 cycles, then release. Requires `cnt`=0, `busy`=0, `done`=0 and `zero`=1 throughout.
- Basic run (WIDTH=8): `start` with `load_val`=3 at edge k. Requires `cnt` = 3,2,1,0 after edges k..k+3, `done`=1 only after k+3, `busy` falling after k+3.
- Pause: `load_val`=5, with `pause`=1 for 2 cycles when `cnt`=3. Requires `cnt` held at 3 for 2 cycles and `done` 2 cycles later than in the unpaused case (after edge k+7).
- Abort:
  - Run with `load_val`=10 and `abort` at `cnt`=6. Requires `cnt`=0 and `busy`=0 on the next edge and no `done`.
  - Repeat with `pause` and `abort` asserted together. Requires the same result, since abort wins.
- Boundaries:
  - `load_val`=0 requires a single `done` pulse and `busy` staying 0.
  - `load_val`=255 requires completion after exactly 255 cycles with no wrap.
  - `start` with `load_val`=7 at `cnt`=4 mid-run is ignored, so `cnt` continues 3,2,1,0.
- Reset mid-run: drop `res` asynchronously while `cnt`=4. Requires immediate `cnt`=0 and `busy`=0, no `done`. A following `start` with `load_val`=2 completes after 2 cycles.
